moore_seq_detector_param: RTL and testbench
===========================================

Name: moore_seq_detector_param

Overview:
Parametrised Moore sequence detector for a serial bit stream. The pattern is runtime-loadable and PAT_LEN bits wide. Overlapping or non-overlapping matching is selected per cycle. Input sampling is qualified by an enable, and a saturating match counter is provided. The block sits on serial data paths as the general-purpose successor to the fixed 1101 detector, and drives a one-cycle registered match flag plus a running match count.

Parameters:
PAT_LEN, 4, pattern length in bits (>=2)
PATTERN_INIT, 4'b1101, pattern register value after reset (PAT_LEN bits)
CNT_W, 8, match counter width

Ports:
Clock  input  1  single clock, all state updates on rising edge
Reset  input  1  asynchronous, active-low reset (0 = reset asserted)
En  input  1  sample qualifier; Din consumed only when En=1
Din  input  1  serial data bit, MSB of pattern arrives first
Overlap  input  1  1 = overlapping matches allowed, 0 = non-overlapping; sampled with each accepted bit
Load  input  1  pattern load strobe
Pattern  input  PAT_LEN  new pattern, captured when Load=1
Y  output  1  Moore match output, registered
Count  output  CNT_W  saturating number of matches since reset/Load

Behaviour:
- Reset=0 (async): pat <= PATTERN_INIT; hist <= 0; fill <= 0; state <= FILL; Y=0; Count=0.
- Internal state: pat (PAT_LEN), hist (PAT_LEN shift register, newest bit in LSB), fill (0..PAT_LEN, saturating count of accepted bits since last restart), state in {FILL, ARMED, MATCH}.
- Y = (state == MATCH). Y is purely a state decode; no combinational path from Din, En or Load.
- Accepted bit (En=1, Load=0):
  - cand = {hist[PAT_LEN-2:0], Din}; hist <= cand.
  - hit = (fill+1 >= PAT_LEN) && (cand == pat).
  - If hit: state <= MATCH; Count <= Count+1, saturating at 2^CNT_W-1.
  - If hit and Overlap=0: fill <= 0 and hist <= 0. The next match needs PAT_LEN fresh bits.
  - If hit and Overlap=1: fill <= PAT_LEN. History is retained, so suffix overlap counts.
  - If no hit: fill <= min(fill+1, PAT_LEN); state <= ARMED if the new fill==PAT_LEN, else FILL.
- En=0, Load=0: hist, fill and Count hold. MATCH -> ARMED (or FILL if fill<PAT_LEN), so Y is high for exactly one cycle per match. FILL and ARMED hold.
- Load=1 (priority over En): pat <= Pattern; hist <= 0; fill <= 0; state <= FILL; Count <= 0; Din ignored that cycle; Y=0 next cycle.
- Latency: Y rises on the clock edge that samples the final pattern bit and is visible for the following cycle. Back-to-back matches (overlap, e.g. pattern 1111 with stream of 1s) keep Y high on consecutive cycles.
- No match is possible while fill+1 < PAT_LEN after reset or Load. The zero-initialised hist never produces a false match against the all-zero pattern.
- Reset asserted mid-stream discards the partial match immediately. The first accepted bit after release counts as bit 1.
- Count saturates and does not wrap. Y still pulses on matches while Count is saturated.

Decomposition:
- Shared package seqdet_pkg holds the state enum type (FILL, ARMED, MATCH), default CNT_W, and the PATTERN_INIT default for 1101.
- One sub-module, sat_counter (parameter W; ports Clock, Reset, inc, clr, q), implements the saturating match counter.
- Detector FSM, shift history and compare stay in the top module.

Test Plan:
- Reset=0 then release, PAT_LEN=4, Overlap=1, En=1, stream 1,1,0,1,1,0,1 -> Y high for 1 cycle after bit 4 and after bit 7; Count=2.
- Same stream with Overlap=0 -> single Y pulse after bit 4; Count=1. Appending 1,1,0,1 then adds one pulse; Count=2.
- Load=1 with Pattern=0110, then stream 0,1,1,0,0,0 -> Count reset to 0; one Y pulse after the 4th accepted bit; Count=1. Old pattern 1101 no longer matches.
- En gaps: 1, (En=0 x3), 1, 0, (En=0), 1 -> Y pulses once, after the final accepted 1. Y=0 during every En=0 cycle; Count=1.
- CNT_W=2, pattern 1111, Overlap=1, eight consecutive 1s -> Y high for 5 consecutive cycles starting after bit 4; Count saturates at 3.
- Reset pulsed low after 1,1,0 -> Y=0 and Count=0 immediately. A following 1 gives no match; then 1,1,0,1 -> one pulse.

Source files
------------

// File: rtl/moore_seq_detector_param_pkg.sv
// Shared types and defaults for the parametrised Moore sequence detector.
package seqdet_pkg;

  // Detector state: still collecting bits, history full, or match reported.
  typedef enum logic [1:0] {
    FILL  = 2'd0,
    ARMED = 2'd1,
    MATCH = 2'd2
  } state_e;

  localparam int unsigned PAT_LEN_DEF      = 4;
  localparam int unsigned CNT_W_DEF        = 8;
  localparam logic [3:0]  PATTERN_INIT_DEF = 4'b1101;

endpackage

// File: rtl/moore_seq_detector_param_if.sv
// Serial stream / pattern load / match report bundle for the sequence detector.
interface moore_seq_detector_param_if
  import seqdet_pkg::*;
#(
  parameter int unsigned PAT_LEN = PAT_LEN_DEF,
  parameter int unsigned CNT_W   = CNT_W_DEF
);

  logic               En;
  logic               Din;
  logic               Overlap;
  logic               Load;
  logic [PAT_LEN-1:0] Pattern;
  logic               Y;
  logic [CNT_W-1:0]   Count;

  modport master (
    output En, Din, Overlap, Load, Pattern,
    input  Y, Count
  );

  modport slave (
    input  En, Din, Overlap, Load, Pattern,
    output Y, Count
  );

endinterface

// File: rtl/moore_seq_detector_param_sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module sat_counter #(
  parameter int unsigned W = 8
) (
  input  logic         Clock,
  input  logic         Reset,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] q
);

  localparam logic [W-1:0] MAX_VAL = '1;

  // Count up on inc, stick at all-ones, clear on clr.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      q <= '0;
    end else if (clr) begin
      q <= '0;
    end else if (inc && (q != MAX_VAL)) begin
      q <= q + W'(1);
    end
  end

endmodule

// File: rtl/moore_seq_detector_param.sv
// Parametrised Moore sequence detector with loadable pattern, overlap select,
// enable-qualified sampling and a saturating match counter.
module moore_seq_detector_param
  import seqdet_pkg::*;
#(
  parameter int unsigned        PAT_LEN      = PAT_LEN_DEF,
  parameter logic [PAT_LEN-1:0] PATTERN_INIT = PAT_LEN'(PATTERN_INIT_DEF),
  parameter int unsigned        CNT_W        = CNT_W_DEF
) (
  input  logic                         Clock,
  input  logic                         Reset,
  moore_seq_detector_param_if.slave    bus
);

  localparam int unsigned FILL_W = $clog2(PAT_LEN + 1);
  localparam int unsigned FW1    = FILL_W + 1;
  localparam logic [FILL_W-1:0] FILL_FULL  = FILL_W'(PAT_LEN);
  localparam logic [FW1-1:0]    FILL_FULL1 = FW1'(PAT_LEN);

  state_e             state_q, state_d;
  logic [PAT_LEN-1:0] pat_q, pat_d;
  logic [PAT_LEN-1:0] hist_q, hist_d;
  logic [FILL_W-1:0]  fill_q, fill_d;
  logic               y_q;
  logic [PAT_LEN-1:0] cand_c;
  logic [FW1-1:0]     fill_inc_c;
  logic               hit_c;
  logic [CNT_W-1:0]   count_q;

  // State, pattern, history and fill registers plus the registered match flag.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state_q <= FILL;
      pat_q   <= PATTERN_INIT;
      hist_q  <= '0;
      fill_q  <= '0;
      y_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      pat_q   <= pat_d;
      hist_q  <= hist_d;
      fill_q  <= fill_d;
      y_q     <= (state_d == MATCH);
    end
  end

  // Next-state: load has priority, then accepted bits, else drop out of MATCH.
  always_comb begin
    state_d    = state_q;
    pat_d      = pat_q;
    hist_d     = hist_q;
    fill_d     = fill_q;
    hit_c      = 1'b0;
    cand_c     = {hist_q[PAT_LEN-2:0], bus.Din};
    fill_inc_c = {1'b0, fill_q} + FW1'(1);

    if (bus.Load) begin
      pat_d   = bus.Pattern;
      hist_d  = '0;
      fill_d  = '0;
      state_d = FILL;
    end else if (bus.En) begin
      hist_d = cand_c;
      hit_c  = (fill_inc_c >= FILL_FULL1) && (cand_c == pat_q);
      if (hit_c) begin
        state_d = MATCH;
        if (bus.Overlap) begin
          fill_d = FILL_FULL;
        end else begin
          fill_d = '0;
          hist_d = '0;
        end
      end else begin
        fill_d  = (fill_inc_c >= FILL_FULL1) ? FILL_FULL : FILL_W'(fill_inc_c);
        state_d = (fill_d == FILL_FULL) ? ARMED : FILL;
      end
    end else if (state_q == MATCH) begin
      state_d = (fill_q == FILL_FULL) ? ARMED : FILL;
    end
  end

  sat_counter #(.W(CNT_W)) u_cnt (
    .Clock (Clock),
    .Reset (Reset),
    .inc   (hit_c),
    .clr   (bus.Load),
    .q     (count_q)
  );

  assign bus.Y     = y_q;
  assign bus.Count = count_q;

endmodule

// File: tb/tb_moore_seq_detector_param.sv
// Directed self-checking bench for moore_seq_detector_param.
module tb_moore_seq_detector_param;

  logic clk = 1'b0;
  logic rst_n;
  int   n_tests = 0;
  int   n_fail  = 0;

  moore_seq_detector_param_if #(.PAT_LEN(4), .CNT_W(8)) b8 ();
  moore_seq_detector_param_if #(.PAT_LEN(4), .CNT_W(2)) b2 ();

  moore_seq_detector_param #(.PAT_LEN(4), .PATTERN_INIT(4'b1101), .CNT_W(8)) dut (
    .Clock (clk),
    .Reset (rst_n),
    .bus   (b8.slave)
  );

  moore_seq_detector_param #(.PAT_LEN(4), .PATTERN_INIT(4'b1111), .CNT_W(2)) dut_sat (
    .Clock (clk),
    .Reset (rst_n),
    .bus   (b2.slave)
  );

  always #5 clk = ~clk;

  // One cycle on the main DUT; outputs are stable 1 time unit after the edge.
  task automatic drive(input logic en, input logic din, input logic ov);
    b8.En = en; b8.Din = din; b8.Overlap = ov; b8.Load = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic do_load(input logic [3:0] p);
    b8.En = 1'b1; b8.Din = 1'b1; b8.Load = 1'b1; b8.Pattern = p;
    @(posedge clk); #1;
    b8.Load = 1'b0; b8.En = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #1;
    n_tests++;
    if (b8.Y !== 1'b0) begin n_fail++; $display("FAIL reset_y: got %b want 0", b8.Y); end
    n_tests++;
    if (b8.Count !== 8'd0) begin n_fail++; $display("FAIL reset_count: got %0d want 0", b8.Count); end
    @(posedge clk); @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    n_tests++;
    if (b2.Count !== 2'd0 || b2.Y !== 1'b0) begin
      n_fail++; $display("FAIL reset_sat: got Y=%b Count=%0d want 0/0", b2.Y, b2.Count);
    end
  endtask

  task automatic test_overlap();
    logic [6:0] s, e;
    s = 7'b1101101; e = 7'b0001001;
    do_load(4'b1101);
    for (int i = 6; i >= 0; i--) begin
      drive(1'b1, s[i], 1'b1);
      n_tests++;
      if (b8.Y !== e[i]) begin n_fail++; $display("FAIL overlap_y bit%0d: got %b want %b", 7 - i, b8.Y, e[i]); end
    end
    n_tests++;
    if (b8.Count !== 8'd2) begin n_fail++; $display("FAIL overlap_count: got %0d want 2", b8.Count); end
  endtask

  task automatic test_nonoverlap();
    logic [10:0] s, e;
    s = 11'b1101101_1101; e = 11'b0001000_0001;
    do_load(4'b1101);
    for (int i = 10; i >= 0; i--) begin
      drive(1'b1, s[i], 1'b0);
      n_tests++;
      if (b8.Y !== e[i]) begin n_fail++; $display("FAIL nonoverlap_y bit%0d: got %b want %b", 11 - i, b8.Y, e[i]); end
      if (i == 4) begin
        n_tests++;
        if (b8.Count !== 8'd1) begin n_fail++; $display("FAIL nonoverlap_count7: got %0d want 1", b8.Count); end
      end
    end
    n_tests++;
    if (b8.Count !== 8'd2) begin n_fail++; $display("FAIL nonoverlap_count: got %0d want 2", b8.Count); end
  endtask

  task automatic test_load();
    logic [5:0] s, e;
    logic [4:0] s2;
    s = 6'b011000; e = 6'b000100; s2 = 5'b11101;
    do_load(4'b0110);
    n_tests++;
    if (b8.Count !== 8'd0 || b8.Y !== 1'b0) begin
      n_fail++; $display("FAIL load_clear: got Y=%b Count=%0d want 0/0", b8.Y, b8.Count);
    end
    for (int i = 5; i >= 0; i--) begin
      drive(1'b1, s[i], 1'b1);
      n_tests++;
      if (b8.Y !== e[i]) begin n_fail++; $display("FAIL load_y bit%0d: got %b want %b", 6 - i, b8.Y, e[i]); end
    end
    for (int i = 4; i >= 0; i--) begin
      drive(1'b1, s2[i], 1'b1);
      n_tests++;
      if (b8.Y !== 1'b0) begin n_fail++; $display("FAIL load_oldpat_y bit%0d: got %b want 0", 5 - i, b8.Y); end
    end
    n_tests++;
    if (b8.Count !== 8'd1) begin n_fail++; $display("FAIL load_count: got %0d want 1", b8.Count); end
  endtask

  task automatic test_en_gaps();
    logic [8:0] en, d, e;
    en = 9'b100011010; d = 9'b111111111; e = 9'b000000010;
    d[6] = 1'b1; d[5] = 1'b1;
    en = 9'b1_000_1_1_0_1_0; d = 9'b1_111_1_0_1_1_1;
    do_load(4'b1101);
    for (int i = 8; i >= 0; i--) begin
      drive(en[i], d[i], 1'b1);
      n_tests++;
      if (b8.Y !== e[i]) begin n_fail++; $display("FAIL engap_y step%0d: got %b want %b", 9 - i, b8.Y, e[i]); end
    end
    n_tests++;
    if (b8.Count !== 8'd1) begin n_fail++; $display("FAIL engap_count: got %0d want 1", b8.Count); end
  endtask

  task automatic test_saturation();
    logic [7:0] e;
    logic [1:0] c [8];
    e = 8'b00011111;
    c = '{2'd0, 2'd0, 2'd0, 2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
    for (int i = 0; i < 8; i++) begin
      b2.En = 1'b1; b2.Din = 1'b1; b2.Overlap = 1'b1; b2.Load = 1'b0;
      @(posedge clk); #1;
      n_tests++;
      if (b2.Y !== e[7 - i] || b2.Count !== c[i]) begin
        n_fail++; $display("FAIL sat bit%0d: got Y=%b Count=%0d want %b/%0d", i + 1, b2.Y, b2.Count, e[7 - i], c[i]);
      end
    end
    b2.En = 1'b0;
    @(posedge clk); #1;
    n_tests++;
    if (b2.Y !== 1'b0 || b2.Count !== 2'd3) begin
      n_fail++; $display("FAIL sat_idle: got Y=%b Count=%0d want 0/3", b2.Y, b2.Count);
    end
  endtask

  task automatic test_reset_midstream();
    logic [4:0] s, e;
    s = 5'b11101; e = 5'b00001;
    drive(1'b1, 1'b1, 1'b1);
    drive(1'b1, 1'b1, 1'b1);
    drive(1'b1, 1'b0, 1'b1);
    b8.En = 1'b0;
    rst_n = 1'b0;
    #1;
    n_tests++;
    if (b8.Y !== 1'b0 || b8.Count !== 8'd0) begin
      n_fail++; $display("FAIL midreset: got Y=%b Count=%0d want 0/0", b8.Y, b8.Count);
    end
    #2;
    rst_n = 1'b1;
    for (int i = 4; i >= 0; i--) begin
      drive(1'b1, s[i], 1'b1);
      n_tests++;
      if (b8.Y !== e[i]) begin n_fail++; $display("FAIL midreset_y bit%0d: got %b want %b", 5 - i, b8.Y, e[i]); end
    end
    n_tests++;
    if (b8.Count !== 8'd1) begin n_fail++; $display("FAIL midreset_count: got %0d want 1", b8.Count); end
  endtask

  initial begin
    b8.En = 1'b0; b8.Din = 1'b0; b8.Overlap = 1'b1; b8.Load = 1'b0; b8.Pattern = 4'b0000;
    b2.En = 1'b0; b2.Din = 1'b0; b2.Overlap = 1'b1; b2.Load = 1'b0; b2.Pattern = 4'b0000;
    test_reset();
    test_overlap();
    test_nonoverlap();
    test_load();
    test_en_gaps();
    test_saturation();
    test_reset_midstream();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
